hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter MUL_LAT, default 4, SHALL set the EX occupancy in cycles of a multi-cycle mult/div; legal range 2..15.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 IDEX_MemRead  in  1  instruction in EX is a load.
REQ-005 IDEX_Rt  in  5  destination register of the load in EX.
REQ-006 IFID_Rs  in  5  first source register of the instruction in ID.
REQ-007 IFID_Rt  in  5  second source register of the instruction in ID.
REQ-008 IFID_UsesRt  in  1  the instruction in ID reads Rt.
REQ-009 IDEX_MulStart  in  1  instruction in EX is a multi-cycle mult/div.
REQ-010 EX_BranchTaken  in  1  branch in EX resolved taken.
REQ-011 PC_Write  out  1  PC update enable.
REQ-012 IFID_Write  out  1  IF/ID register load enable.
REQ-013 IDEX_Bubble  out  1  zero the control fields loaded into ID/EX.
REQ-014 IFID_Flush  out  1  clear the IF/ID instruction to a NOP.
REQ-015 EX_Hold  out  1  hold the ID/EX register and EX stage contents.
REQ-016 StallCount  out  16  saturating count of cycles with PC_Write=0.

Function
REQ-017 The block SHALL implement FSM states RUN, LOAD_STALL, MUL_BUSY, plus a 4-bit down-counter cnt.
REQ-018 The load-use hit SHALL be: IDEX_MemRead & (IDEX_Rt!=0) & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
REQ-019 Default outputs in every state SHALL be: PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0, EX_Hold=0; outputs are combinational from state, cnt and inputs.
REQ-020 RUN SHALL apply the priority order IDEX_MulStart > EX_BranchTaken > load-use hit.
REQ-021 RUN with IDEX_MulStart=1: EX_Hold=1, PC_Write=0, IFID_Write=0; next state MUL_BUSY; cnt loaded MUL_LAT-2.
REQ-022 RUN with EX_BranchTaken=1 (no MulStart): IFID_Flush=1, IDEX_Bubble=1, PC_Write=1; next state RUN.
REQ-023 RUN with a load-use hit (no MulStart, no branch): PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next state LOAD_STALL.
REQ-024 LOAD_STALL SHALL drive default outputs, ignore all hazard inputs, and go to RUN unconditionally, so each load-use stall lasts exactly one cycle.
REQ-025 MUL_BUSY with cnt!=0: EX_Hold=1, PC_Write=0, IFID_Write=0, IDEX_Bubble=0; cnt decrements by 1.
REQ-026 MUL_BUSY with cnt==0: default outputs; next state RUN.
REQ-027 MUL_BUSY SHALL ignore IDEX_MulStart, EX_BranchTaken and the load-use hit.
REQ-028 A mult/div SHALL occupy EX for exactly MUL_LAT cycles, with EX_Hold high for MUL_LAT-1 of them.
REQ-029 StallCount SHALL increment on every edge where PC_Write=0 and hold at 16'hFFFF once reached; it never wraps.
REQ-030 Register 0 as a load destination SHALL never cause a stall.

Reset
REQ-031 While rst=1, state SHALL be RUN, cnt=0 and StallCount=0; outputs SHALL be PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0, EX_Hold=0, independent of clk.
REQ-032 Reset asserted in LOAD_STALL or MUL_BUSY SHALL abort immediately to RUN; after release, the first edge SHALL evaluate inputs as RUN.

Verification
REQ-033 Load-use on Rs: MemRead=1, IDEX_Rt=3, IFID_Rs=3 -> one cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1, then defaults with inputs unchanged; StallCount=1.
REQ-034 Rt gating and register 0: IDEX_Rt=5, IFID_Rt=5, IFID_UsesRt=0 -> no stall; set UsesRt=1 -> stall; IDEX_Rt=0, IFID_Rs=0 -> no stall.
REQ-035 MUL_LAT=4, MulStart pulse held high -> EX_Hold=1 for 3 cycles, then 0 for 1 cycle, then RUN; StallCount increases by 3.
REQ-036 Priority: MulStart=1, BranchTaken=1 and a load-use hit all in RUN -> MulStart path only; BranchTaken=1 with a load-use hit -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, no LOAD_STALL entry.
REQ-037 Reset mid-MUL_BUSY (after cycle 1 of MUL_LAT=4) -> outputs return to defaults asynchronously, StallCount=0, and the next MulStart runs the full 4 cycles.
REQ-038 Saturation: force 70000 consecutive load-use stalls -> StallCount reaches 16'hFFFF and stays there.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline hazard controller for a classic five-stage core. It resolves three
// kinds of hazard seen from the ID and EX stages:
//   * multi-cycle mult/div in EX   -> hold EX and freeze the front end
//   * taken branch resolved in EX  -> squash the wrong-path instruction in ID
//   * load-use dependency          -> one-cycle stall with a bubble into EX
// It also keeps a saturating count of the cycles in which the PC was frozen.
//
// Parameters
//   MUL_LAT        EX occupancy of a mult/div in cycles (legal range 2..15)
//
// Ports
//   clk            single clock, all state updates on its rising edge
//   rst            asynchronous active-high reset
//   IDEX_MemRead   instruction in EX is a load
//   IDEX_Rt        destination register of the load in EX
//   IFID_Rs        first source register of the instruction in ID
//   IFID_Rt        second source register of the instruction in ID
//   IFID_UsesRt    instruction in ID actually reads Rt
//   IDEX_MulStart  instruction in EX is a multi-cycle mult/div
//   EX_BranchTaken branch in EX resolved taken
//   PC_Write       PC update enable
//   IFID_Write     IF/ID register load enable
//   IDEX_Bubble    zero the control fields loaded into ID/EX
//   IFID_Flush     clear the IF/ID instruction to a NOP
//   EX_Hold        hold the ID/EX register and EX stage contents
//   StallCount     saturating count of cycles with PC_Write low
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRt,
    input  logic        IDEX_MulStart,
    input  logic        EX_BranchTaken,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        EX_Hold,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MUL_BUSY   = 2'd2
    } hazardStateT;

    // The RUN cycle that sees MulStart already holds EX once, and the final
    // MUL_BUSY cycle with cnt==0 releases it, so the counter starts at
    // MUL_LAT-2 to give MUL_LAT cycles of occupancy and MUL_LAT-1 of hold.
    localparam logic [3:0]  MUL_CNT_INIT    = 4'(MUL_LAT - 32'd2);
    localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

    // Load-use dependency between the load in EX and the instruction in ID.
    // Register 0 is hardwired to zero, so a load into it never creates one.
    function automatic logic loadUseHit(
        input logic       memRead,
        input logic [4:0] exRt,
        input logic [4:0] idRs,
        input logic [4:0] idRt,
        input logic       idUsesRt
    );
        logic rsMatch;
        logic rtMatch;
        rsMatch = (exRt == idRs);
        rtMatch = idUsesRt & (exRt == idRt);
        return memRead & (exRt != 5'd0) & (rsMatch | rtMatch);
    endfunction

    hazardStateT stateR;
    hazardStateT stateNextS;
    logic [3:0]  cntR;
    logic [3:0]  cntNextS;
    logic [15:0] stallCountR;
    logic        loadUseHitS;

    logic        pcWriteS;
    logic        ifidWriteS;
    logic        idexBubbleS;
    logic        ifidFlushS;
    logic        exHoldS;

    assign loadUseHitS = loadUseHit(IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt);

    // Next-state, counter and control-output decode.
    always_comb begin
        stateNextS  = stateR;
        cntNextS    = cntR;
        pcWriteS    = 1'b1;
        ifidWriteS  = 1'b1;
        idexBubbleS = 1'b0;
        ifidFlushS  = 1'b0;
        exHoldS     = 1'b0;

        if (rst) begin
            // Outputs stay at their defaults for as long as reset is held,
            // whatever the hazard inputs are doing.
            stateNextS = RUN;
            cntNextS   = 4'd0;
        end else begin
            case (stateR)
                RUN: begin
                    if (IDEX_MulStart) begin
                        exHoldS    = 1'b1;
                        pcWriteS   = 1'b0;
                        ifidWriteS = 1'b0;
                        stateNextS = MUL_BUSY;
                        cntNextS   = MUL_CNT_INIT;
                    end else if (EX_BranchTaken) begin
                        // The PC still advances to the branch target.
                        ifidFlushS  = 1'b1;
                        idexBubbleS = 1'b1;
                        stateNextS  = RUN;
                    end else if (loadUseHitS) begin
                        pcWriteS    = 1'b0;
                        ifidWriteS  = 1'b0;
                        idexBubbleS = 1'b1;
                        stateNextS  = LOAD_STALL;
                    end else begin
                        stateNextS = RUN;
                    end
                end

                LOAD_STALL: begin
                    // The load has moved on to MEM, so the dependency is now
                    // covered by forwarding; hazard inputs are not looked at.
                    stateNextS = RUN;
                end

                MUL_BUSY: begin
                    if (cntR != 4'd0) begin
                        exHoldS    = 1'b1;
                        pcWriteS   = 1'b0;
                        ifidWriteS = 1'b0;
                        cntNextS   = cntR - 4'd1;
                    end else begin
                        stateNextS = RUN;
                    end
                end

                default: begin
                    stateNextS = RUN;
                    cntNextS   = 4'd0;
                end
            endcase
        end
    end

    // State and mult/div occupancy counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= RUN;
            cntR   <= 4'd0;
        end else begin
            stateR <= stateNextS;
            cntR   <= cntNextS;
        end
    end

    // Saturating count of frozen-PC cycles; it parks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCountR <= 16'd0;
        end else if (!pcWriteS && (stallCountR != STALL_COUNT_MAX)) begin
            stallCountR <= stallCountR + 16'd1;
        end else begin
            stallCountR <= stallCountR;
        end
    end

    assign PC_Write    = pcWriteS;
    assign IFID_Write  = ifidWriteS;
    assign IDEX_Bubble = idexBubbleS;
    assign IFID_Flush  = ifidFlushS;
    assign EX_Hold     = exHoldS;
    assign StallCount  = stallCountR;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench for hazard_stall_unit. A MUL_LAT=4 instance covers the
// functional scenarios; a MUL_LAT=15 instance, fed a continuous mult/div
// stream, drives the stall counter into saturation in the fewest cycles.
// Control outputs are compared as the vector
// {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, EX_Hold}.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic [4:0]  exRt;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        usesRt;
    logic        mulStart;
    logic        branchTaken;
    logic        pcWrite;
    logic        ifidWrite;
    logic        idexBubble;
    logic        ifidFlush;
    logic        exHold;
    logic [15:0] stallCount;
    logic [4:0]  outs;

    logic        satMulStart;
    logic        satPcWrite;
    logic        satIfidWrite;
    logic        satIdexBubble;
    logic        satIfidFlush;
    logic        satExHold;
    logic [15:0] satCount;

    int checks;
    int failures;

    assign outs = {pcWrite, ifidWrite, idexBubble, ifidFlush, exHold};

    hazard_stall_unit #(.MUL_LAT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .IDEX_MemRead   (memRead),
        .IDEX_Rt        (exRt),
        .IFID_Rs        (idRs),
        .IFID_Rt        (idRt),
        .IFID_UsesRt    (usesRt),
        .IDEX_MulStart  (mulStart),
        .EX_BranchTaken (branchTaken),
        .PC_Write       (pcWrite),
        .IFID_Write     (ifidWrite),
        .IDEX_Bubble    (idexBubble),
        .IFID_Flush     (ifidFlush),
        .EX_Hold        (exHold),
        .StallCount     (stallCount)
    );

    hazard_stall_unit #(.MUL_LAT(15)) dutSat (
        .clk            (clk),
        .rst            (rst),
        .IDEX_MemRead   (1'b0),
        .IDEX_Rt        (5'd0),
        .IFID_Rs        (5'd0),
        .IFID_Rt        (5'd0),
        .IFID_UsesRt    (1'b0),
        .IDEX_MulStart  (satMulStart),
        .EX_BranchTaken (1'b0),
        .PC_Write       (satPcWrite),
        .IFID_Write     (satIfidWrite),
        .IDEX_Bubble    (satIdexBubble),
        .IFID_Flush     (satIfidFlush),
        .EX_Hold        (satExHold),
        .StallCount     (satCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearIn();
        memRead     = 1'b0;
        exRt        = 5'd0;
        idRs        = 5'd0;
        idRt        = 5'd0;
        usesRt      = 1'b0;
        mulStart    = 1'b0;
        branchTaken = 1'b0;
    endtask

    task automatic setLoadUse();
        memRead = 1'b1;
        exRt    = 5'd3;
        idRs    = 5'd3;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        satMulStart = 1'b0;
        clearIn();
        setLoadUse();
        mulStart    = 1'b1;
        branchTaken = 1'b1;
        #3;
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL reset_outs_pre_edge: got %b want %b", outs, 5'b11000);
        end
        tick();
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL reset_outs_after_edge: got %b want %b", outs, 5'b11000);
        end
        checks++;
        if (stallCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d want %0d", stallCount, 0);
        end
        clearIn();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL reset_release_idle: got %b want %b", outs, 5'b11000);
        end
        tick();
    endtask

    task automatic test_load_use_rs();
        setLoadUse();
        idRt = 5'd7;
        #1;
        checks++;
        if (outs !== 5'b00100) begin
            failures++;
            $display("FAIL loaduse_rs_stall: got %b want %b", outs, 5'b00100);
        end
        tick();
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL loaduse_rs_second_cycle: got %b want %b", outs, 5'b11000);
        end
        checks++;
        if (stallCount !== 16'd1) begin
            failures++;
            $display("FAIL loaduse_rs_count: got %0d want %0d", stallCount, 1);
        end
        tick();
        clearIn();
        #1;
        checks++;
        if (outs !== 5'b11000 || stallCount !== 16'd1) begin
            failures++;
            $display("FAIL loaduse_rs_done: got %b/%0d want %b/%0d", outs, stallCount, 5'b11000, 1);
        end
    endtask

    task automatic test_rt_gating();
        memRead = 1'b1;
        exRt    = 5'd5;
        idRt    = 5'd5;
        idRs    = 5'd9;
        usesRt  = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL rt_unused_no_stall: got %b want %b", outs, 5'b11000);
        end
        usesRt = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00100) begin
            failures++;
            $display("FAIL rt_used_stall: got %b want %b", outs, 5'b00100);
        end
        tick();
        tick();
        memRead = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL no_memread_no_stall: got %b want %b", outs, 5'b11000);
        end
        memRead = 1'b1;
        exRt    = 5'd0;
        idRs    = 5'd0;
        idRt    = 5'd0;
        #1;
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL reg0_no_stall: got %b want %b", outs, 5'b11000);
        end
        tick();
        checks++;
        if (outs !== 5'b11000 || stallCount !== 16'd2) begin
            failures++;
            $display("FAIL rt_gating_count: got %b/%0d want %b/%0d", outs, stallCount, 5'b11000, 2);
        end
        clearIn();
    endtask

    task automatic test_mul();
        mulStart = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00001) begin
            failures++;
            $display("FAIL mul_start: got %b want %b", outs, 5'b00001);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (i == 0) begin
                // Hazards arriving during the busy period must be ignored.
                branchTaken = 1'b1;
                setLoadUse();
            end
            #1;
            checks++;
            if (outs !== 5'b00001) begin
                failures++;
                $display("FAIL mul_busy_hold[%0d]: got %b want %b", i, outs, 5'b00001);
            end
        end
        tick();
        checks++;
        if (outs !== 5'b11000) begin
            failures++;
            $display("FAIL mul_last_cycle: got %b want %b", outs, 5'b11000);
        end
        checks++;
        if (stallCount !== 16'd5) begin
            failures++;
            $display("FAIL mul_count: got %0d want %0d", stallCount, 5);
        end
        clearIn();
        tick();
        branchTaken = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b11110 || stallCount !== 16'd5) begin
            failures++;
            $display("FAIL mul_back_in_run: got %b/%0d want %b/%0d", outs, stallCount, 5'b11110, 5);
        end
        clearIn();
    endtask

    task automatic test_priority();
        mulStart    = 1'b1;
        branchTaken = 1'b1;
        setLoadUse();
        #1;
        checks++;
        if (outs !== 5'b00001) begin
            failures++;
            $display("FAIL prio_mul_wins: got %b want %b", outs, 5'b00001);
        end
        tick();
        clearIn();
        #1;
        checks++;
        if (outs !== 5'b00001) begin
            failures++;
            $display("FAIL prio_mul_busy: got %b want %b", outs, 5'b00001);
        end
        tick();
        tick();
        tick();
        branchTaken = 1'b1;
        setLoadUse();
        #1;
        checks++;
        if (outs !== 5'b11110) begin
            failures++;
            $display("FAIL prio_branch_over_load: got %b want %b", outs, 5'b11110);
        end
        tick();
        branchTaken = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00100) begin
            failures++;
            $display("FAIL prio_no_load_stall_entry: got %b want %b", outs, 5'b00100);
        end
        tick();
        clearIn();
        tick();
        checks++;
        if (stallCount !== 16'd9) begin
            failures++;
            $display("FAIL prio_count: got %0d want %0d", stallCount, 9);
        end
    endtask

    task automatic test_reset_mid_mul();
        mulStart = 1'b1;
        tick();
        mulStart = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00001 || stallCount !== 16'd10) begin
            failures++;
            $display("FAIL midmul_busy: got %b/%0d want %b/%0d", outs, stallCount, 5'b00001, 10);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b11000 || stallCount !== 16'd0) begin
            failures++;
            $display("FAIL midmul_async_reset: got %b/%0d want %b/%0d", outs, stallCount, 5'b11000, 0);
        end
        #2 rst = 1'b0;
        mulStart = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00001) begin
            failures++;
            $display("FAIL midmul_restart: got %b want %b", outs, 5'b00001);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (outs !== 5'b00001) begin
                failures++;
                $display("FAIL midmul_full_hold[%0d]: got %b want %b", i, outs, 5'b00001);
            end
        end
        tick();
        checks++;
        if (outs !== 5'b11000 || stallCount !== 16'd3) begin
            failures++;
            $display("FAIL midmul_full_end: got %b/%0d want %b/%0d", outs, stallCount, 5'b11000, 3);
        end
        clearIn();
        tick();
    endtask

    task automatic test_saturation();
        int          reachEdge;
        logic [15:0] countBefore;
        reachEdge   = 0;
        countBefore = 16'd0;
        checks++;
        if (satCount !== 16'd0) begin
            failures++;
            $display("FAIL sat_start: got %0d want %0d", satCount, 0);
        end
        // MUL_LAT=15: 14 stalled cycles out of every 15, so all-ones is hit
        // on edge 15*4681 + 1 = 70216.
        satMulStart = 1'b1;
        for (int i = 1; i <= 72000; i++) begin
            tick();
            if (i == 70215) begin
                countBefore = satCount;
            end
            if (satCount == 16'hFFFF) begin
                reachEdge = i;
                break;
            end
        end
        checks++;
        if (reachEdge != 70216) begin
            failures++;
            $display("FAIL sat_reach_edge: got %0d want %0d", reachEdge, 70216);
        end
        checks++;
        if (countBefore !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_one_before: got %h want %h", countBefore, 16'hFFFE);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        checks++;
        if (satCount !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold: got %h want %h", satCount, 16'hFFFF);
        end
        satMulStart = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_use_rs();
        test_rt_gating();
        test_mul();
        test_priority();
        test_reset_mid_mul();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
